// File: rtl/display_scheduler_if.sv
// display_scheduler_if: frame-synchronous update handshake between the datapath and the display scheduler
interface display_scheduler_if;
  logic [15:0] digits_in;
  logic [3:0] mask_in;
  logic upd_req;
  logic upd_ack;
  modport master(output digits_in, mask_in, upd_req, input upd_ack);
  modport slave(input digits_in, mask_in, upd_req, output upd_ack);
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: blank/show four-digit multiplexer with a shadow register loaded only at frame start
module display_scheduler #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input logic clk,
  input logic btnC,
  display_scheduler_if.slave bus,
  output logic [3:0] an,
  output logic [1:0] digit_sel,
  output logic [3:0] digit_val,
  output logic frame_done
);
  typedef enum logic {PH_BLANK, PH_SHOW} phase_t;
  phase_t phase_q, phase_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d, sd_q, sd_d;
  logic [3:0] sm_q, sm_d;
  logic ack_q, ack_d, fd_q, fd_d, last, cap;
  always_comb begin
    last = cnt_q == (phase_q == PH_SHOW ? 16'(DWELL - 1) : 16'(BLANK - 1));
    cap = last && phase_q == PH_BLANK && idx_q == 2'd0 && bus.upd_req;
    phase_d = last ? (phase_q == PH_SHOW ? PH_BLANK : PH_SHOW) : phase_q;
    cnt_d = last ? 16'd0 : cnt_q + 16'd1;
    idx_d = (last && phase_q == PH_SHOW) ? idx_q + 2'd1 : idx_q;
    sd_d = cap ? bus.digits_in : sd_q;
    sm_d = cap ? bus.mask_in : sm_q;
    ack_d = cap;
    fd_d = last && phase_q == PH_SHOW && idx_q == 2'd3;
  end
  always_ff @(posedge clk) begin
    if (btnC) begin
      phase_q <= PH_BLANK;
      idx_q <= 2'd0;
      cnt_q <= 16'd0;
      sd_q <= 16'd0;
      sm_q <= 4'b1111;
      ack_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      sd_q <= sd_d;
      sm_q <= sm_d;
      ack_q <= ack_d;
      fd_q <= fd_d;
    end
  end
  assign an = (phase_q == PH_SHOW && sm_q[idx_q]) ? ~(4'b0001 << idx_q) : 4'b1111;
  assign digit_sel = idx_q;
  assign digit_val = sd_q[{idx_q, 2'b00} +: 4];
  assign frame_done = fd_q;
  assign bus.upd_ack = ack_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: table, directed and random checks of two display_scheduler configurations against a cycle-count model
module tb_display_scheduler;
  logic clk = 1'b0;
  logic btnC = 1'b1;
  logic req = 1'b0;
  logic [15:0] din = 16'd0;
  logic [3:0] msk = 4'hF;
  logic [1:0][3:0] an_o, val_o;
  logic [1:0][1:0] sel_o;
  logic [1:0] fd_o, ack_o;
  int checks = 0, failures = 0, t = 0;
  int dw[2] = '{4, 2};
  int bl[2] = '{1, 3};
  logic [1:0][15:0] msd;
  logic [1:0][3:0] msm;
  logic [1:0] mack;
  always #5 clk = ~clk;
  display_scheduler_if ifa();
  display_scheduler_if ifb();
  assign ifa.upd_req = req;
  assign ifa.digits_in = din;
  assign ifa.mask_in = msk;
  assign ifb.upd_req = req;
  assign ifb.digits_in = din;
  assign ifb.mask_in = msk;
  assign ack_o = {ifb.upd_ack, ifa.upd_ack};
  display_scheduler #(.DWELL(4), .BLANK(1)) dut_a (
    .clk(clk), .btnC(btnC), .bus(ifa.slave), .an(an_o[0]), .digit_sel(sel_o[0]),
    .digit_val(val_o[0]), .frame_done(fd_o[0])
  );
  display_scheduler #(.DWELL(2), .BLANK(3)) dut_b (
    .clk(clk), .btnC(btnC), .bus(ifb.slave), .an(an_o[1]), .digit_sel(sel_o[1]),
    .digit_val(val_o[1]), .frame_done(fd_o[1])
  );
  typedef struct {
    int c;
    logic [3:0] an;
    logic [3:0] val;
    logic ack;
    logic fd;
  } vec_t;
  task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h expected=%h", n, t, act, exp);
    end
  endtask
  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      int p = dw[i] + bl[i];
      int pos = t % (4 * p);
      int s = pos / p;
      logic sh = (pos % p) >= bl[i];
      logic [3:0] one = 4'b0001;
      logic [3:0] ea = (sh && msm[i][s]) ? ~(one << s) : 4'hF;
      chk(i ? "b_an" : "a_an", 16'(an_o[i]), 16'(ea));
      chk(i ? "b_sel" : "a_sel", 16'(sel_o[i]), 16'(s));
      chk(i ? "b_val" : "a_val", 16'(val_o[i]), 16'(msd[i][4*s+:4]));
      chk(i ? "b_ack" : "a_ack", 16'(ack_o[i]), 16'(mack[i]));
      chk(i ? "b_fd" : "a_fd", 16'(fd_o[i]), 16'(t > 0 && pos == 0));
    end
  endtask
  task automatic model_edge();
    if (btnC) begin
      t = 0;
      msd = '0;
      msm = {4'hF, 4'hF};
      mack = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mack[i] = req && (t % (4 * (dw[i] + bl[i]))) == bl[i] - 1;
        if (mack[i]) begin
          msd[i] = din;
          msm[i] = msk;
        end
      end
      t++;
    end
  endtask
  task automatic step();
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    btnC = 1'b1;
    req = 1'b0;
    step();
    btnC = 1'b0;
  endtask
  initial begin
    vec_t tbl[14] = '{
      '{0, 4'hF, 4'h0, 1'b0, 1'b0}, '{1, 4'hE, 4'h1, 1'b1, 1'b0}, '{4, 4'hE, 4'h1, 1'b0, 1'b0},
      '{5, 4'hF, 4'h2, 1'b0, 1'b0}, '{6, 4'hD, 4'h2, 1'b0, 1'b0}, '{9, 4'hD, 4'h2, 1'b0, 1'b0},
      '{10, 4'hF, 4'h3, 1'b0, 1'b0}, '{11, 4'hB, 4'h3, 1'b0, 1'b0}, '{14, 4'hB, 4'h3, 1'b0, 1'b0},
      '{15, 4'hF, 4'h4, 1'b0, 1'b0}, '{16, 4'h7, 4'h4, 1'b0, 1'b0}, '{19, 4'h7, 4'h4, 1'b0, 1'b0},
      '{20, 4'hF, 4'h1, 1'b0, 1'b1}, '{21, 4'hE, 4'h5, 1'b1, 1'b0}
    };
    int k, fdn;
    int lit[4];
    msd = '0;
    msm = {4'hF, 4'hF};
    mack = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step();
    btnC = 1'b0;
    k = 0;
    for (int c = 0; c < 22; c++) begin
      req = c == 0 || (c >= 7 && c < 21);
      din = c >= 7 ? 16'h8765 : 16'h4321;
      msk = 4'hF;
      if (k < 14 && tbl[k].c == c) begin
        chk("load_an", 16'(an_o[0]), 16'(tbl[k].an));
        chk("load_val", 16'(val_o[0]), 16'(tbl[k].val));
        chk("load_ack", 16'(ack_o[0]), 16'(tbl[k].ack));
        chk("load_fd", 16'(fd_o[0]), 16'(tbl[k].fd));
        k++;
      end
      step();
    end
    do_reset();
    for (int c = 0; c < 21; c++) begin
      req = c == 0;
      din = 16'h4321;
      msk = 4'b0101;
      chk("mask_an", 16'(an_o[0]), (c >= 1 && c <= 4) ? 16'hE : (c >= 11 && c <= 14) ? 16'hB : 16'hF);
      if (c == 20) chk("mask_fd", 16'(fd_o[0]), 16'd1);
      step();
    end
    do_reset();
    for (int c = 0; c < 12; c++) step();
    btnC = 1'b1;
    req = 1'b1;
    din = 16'h9ABC;
    msk = 4'hF;
    step();
    btnC = 1'b0;
    chk("rst_mid_an", 16'(an_o[0]), 16'hF);
    chk("rst_mid_sel", 16'(sel_o[0]), 16'd0);
    chk("rst_mid_val", 16'(val_o[0]), 16'd0);
    chk("rst_mid_ack", 16'(ack_o[0]), 16'd0);
    step();
    chk("rst_cap_ack", 16'(ack_o[0]), 16'd1);
    chk("rst_cap_val", 16'(val_o[0]), 16'hC);
    chk("rst_cap_an", 16'(an_o[0]), 16'hE);
    req = 1'b0;
    step();
    do_reset();
    fdn = 0;
    lit = '{0, 0, 0, 0};
    for (int c = 0; c < 61; c++) begin
      chk("wrap_sel", 16'(sel_o[1]), 16'((c % 20) / 5));
      if (an_o[1] != 4'hF) lit[sel_o[1]]++;
      if (fd_o[1]) fdn++;
      step();
    end
    for (int d = 0; d < 4; d++) chk("wrap_lit", 16'(lit[d]), 16'd6);
    chk("wrap_fd_count", 16'(fdn), 16'd3);
    for (int c = 0; c < 400; c++) begin
      btnC = $urandom_range(0, 49) == 0;
      req = 1'($urandom_range(0, 1));
      din = 16'($urandom);
      msk = 4'($urandom);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-multiplexing controller that shares the single seven-segment decoder among the four display digits. It steps a digit index through a fixed SHOW/BLANK schedule and drives the active-low anodes. It presents the selected 4-bit digit value to the decoder and holds all four values in a shadow register. The shadow register is updated only at frame boundaries through a req/ack handshake, so the math datapath (A, B, A+B, A−B) never tears the display mid-frame.

## Interface
- `DWELL`, default 4: cycles each digit is driven per frame; legal range 1..65535.
- `BLANK`, default 1: all-anodes-off cycles before each digit (ghosting guard); legal range 1..65535.
- `clk` input 1: board clock; all state changes on the rising edge.
- `btnC` input 1: reset; one clock, reset is synchronous and active-high.
- `digits_in` input 16: four nibbles; digit k = `digits_in[4k+3:4k]`.
- `mask_in` input 4: per-digit enable; 0 blanks that digit's anode.
- `upd_req` input 1: level request to load `digits_in`/`mask_in` into shadow.
- `upd_ack` output 1: one-cycle pulse; the shadow was loaded on the previous edge.
- `an` output 4: active-low anodes to the display.
- `digit_sel` output 2: current digit index.
- `digit_val` output 4: shadow nibble for `digit_sel`; feeds the decoder.
- `frame_done` output 1: one-cycle pulse at the start of each new frame.

## Operation
- State: `phase` ∈ {BLANK, SHOW}, `idx` (2 bits), `cnt` (16 bits), `shadow_d` (16 bits), `shadow_m` (4 bits).
- Reset (`btnC`=1 at an edge): phase=BLANK, idx=0, cnt=0, shadow_d=0, shadow_m=4'b1111.
  - Registered pulses `upd_ack` and `frame_done` are cleared to 0.
  - Reset has priority over every other event, including a capture in the same cycle.
- BLANK:
  - Drives an=4'b1111.
  - cnt counts 0..BLANK-1.
  - At cnt=BLANK-1: phase→SHOW, cnt→0.
- SHOW:
  - Drives an = ~(4'b0001<<idx) if shadow_m[idx]=1, else 4'b1111.
  - cnt counts 0..DWELL-1.
  - At cnt=DWELL-1: phase→BLANK, cnt→0, idx→idx+1 mod 4 (3 wraps to 0).
- Output decode:
  - digit_sel = idx and digit_val = shadow_d[4·idx+:4] in both phases.
  - These outputs and `an` are decoded directly from the registered state, with no extra stage.
- Capture:
  - Condition: phase=BLANK, idx=0, cnt=BLANK-1 and upd_req=1.
  - On that edge, shadow_d←digits_in and shadow_m←mask_in; `upd_ack`=1 for the following cycle.
  - This is the only capture point, one per frame.
- Handshake rules:
  - The requester holds `digits_in`/`mask_in` stable while upd_req=1 and drops upd_req in the cycle `upd_ack` is seen.
  - If upd_req stays high, the next frame captures again. This is legal and idempotent.
  - A req raised or dropped at any other time has no effect on the display.
- frame_done: registered pulse, high for the first BLANK cycle of idx=0 following digit 3. It is not asserted for the first frame after reset.
- Masked digits keep their slot timing; only the anode is suppressed.

## Timing
- Frame length is 4·(DWELL+BLANK) cycles; the schedule is independent of the inputs.
- Defaults give a 20-cycle frame. With cycle 0 = first cycle after reset deasserts:
  - blank at 0; digit0 at 1–4.
  - blank at 5; digit1 at 6–9.
  - blank at 10; digit2 at 11–14.
  - blank at 15; digit3 at 16–19.
  - next frame starts at 20.
- Capture-to-display latency is 1 cycle: values captured at the edge ending the cycle-0 blank appear at cycle 1, coincident with `upd_ack`.
- Worst-case req-to-ack latency is 4·(DWELL+BLANK) cycles.
- No anode is ever active in two consecutive cycles with different idx, since BLANK ≥ 1.
- Reset mid-operation: the next cycle shows reset state (an=1111, digit_sel=0, digit_val=0). A pending request is not acknowledged until the first capture point after reset.

## Test plan
- Reset: hold btnC 3 cycles, then release.
  - Required: an=4'b1111, digit_sel=0, digit_val=0, upd_ack=0, frame_done=0 while held.
  - Required: digit0 anode (an=4'b1110) at cycle 1 after release.
- Load: upd_req=1, digits_in=16'h4321, mask_in=4'b1111 from cycle 0 (defaults).
  - Required: upd_ack at cycle 1.
  - Required: an/digit_val = 1110/1 (cycles 1–4), 1101/2 (6–9), 1011/3 (11–14), 0111/4 (16–19).
  - Required: an=1111 at cycles 0, 5, 10, 15.
  - Required: frame_done at cycle 20.
- Mid-frame request: after the load, raise upd_req at cycle 7 with 16'h8765.
  - Required: digit_val stays 2/3/4 through cycle 19.
  - Required: capture at cycle 20, upd_ack and digit_val=5 at cycle 21.
- Mask: load mask_in=4'b0101, digits_in=16'h4321.
  - Required: an=1110 at cycles 1–4 and 1011 at 11–14; an=1111 during digit1/digit3 slots.
  - Required: frame_done still at cycle 20.
- Reset mid-frame: assert btnC for one cycle at cycle 12, with upd_req=1 raised at cycle 12.
  - Required: at cycle 13, an=1111, digit_sel=0, digit_val=0, and no upd_ack.
  - Required: the schedule restarts as from reset, with capture at the first post-reset capture point.
- Wrap and parameters: DWELL=2, BLANK=3, run 3 frames.
  - Required: 20-cycle frames.
  - Required: digit_sel sequence 0,1,2,3,0,… with each digit lit exactly 2 cycles per frame.
  - Required: exactly one frame_done per frame boundary.
